// File: rtl/mul_div_pkg.sv
// Shared definitions for the RV M-extension multiply/divide unit:
// funct3 op encodings, FSM state encoding and the iteration-counter sizing constant.
package mul_div_pkg;

  // RV32M/RV64M funct3 encodings
  localparam logic [2:0] OpMul    = 3'b000;
  localparam logic [2:0] OpMulh   = 3'b001;
  localparam logic [2:0] OpMulhsu = 3'b010;
  localparam logic [2:0] OpMulhu  = 3'b011;
  localparam logic [2:0] OpDiv    = 3'b100;
  localparam logic [2:0] OpDivu   = 3'b101;
  localparam logic [2:0] OpRem    = 3'b110;
  localparam logic [2:0] OpRemu   = 3'b111;

  // log2 of the widest supported datapath (64); the counter gets one extra bit
  localparam int unsigned XLEN_LOG2 = 6;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StCalc = 2'd1,
    StDone = 2'd2
  } state_e;

endpackage

// File: rtl/mul_div_divider.sv
// Restoring divider datapath: partial remainder and quotient shift register.
// Operates on magnitudes only; sign handling lives in the parent unit.
// For word ops the 32-bit dividend is pre-aligned to the top of the shift register
// so that 32 steps leave the quotient in the low half.
module mul_div_divider
  import mul_div_pkg::*;
#(
  parameter int unsigned XLEN = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            step,
  input  logic            word,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] quo_next,
  output logic [XLEN-1:0] rem_next
);

  logic [XLEN-1:0] rem_q;
  logic [XLEN-1:0] quo_q;
  logic [XLEN-1:0] dsr_q;
  logic [XLEN:0]   shifted;
  logic [XLEN:0]   diff;
  logic            qbit;

  // One restoring step: shift in the next dividend bit and trial-subtract the divisor.
  always_comb begin
    shifted  = {rem_q, quo_q[XLEN-1]};
    diff     = shifted - {1'b0, dsr_q};
    // A borrow shows up in the top bit because shifted < 2 * divisor always holds
    qbit     = ~diff[XLEN];
    rem_next = qbit ? diff[XLEN-1:0] : shifted[XLEN-1:0];
    quo_next = {quo_q[XLEN-2:0], qbit};
  end

  // Load operands on accept, advance one quotient bit per step.
  always_ff @(posedge clk) begin
    if (rst) begin
      rem_q <= '0;
      quo_q <= '0;
      dsr_q <= '0;
    end else if (load) begin
      rem_q <= '0;
      dsr_q <= divisor;
      quo_q <= word ? (dividend << 32) : dividend;
    end else if (step) begin
      rem_q <= rem_next;
      quo_q <= quo_next;
    end
  end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative RV M-extension multiply/divide unit (1 bit per cycle).
// Optional feature macro MUL_DIV_FAST_MUL_EN: multiplies use a single combinational
// product latched in one cycle; divides stay iterative.
module mul_div_unit
  import mul_div_pkg::*;
#(
  parameter int unsigned XLEN  = 64,
  parameter int unsigned W_OPS = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      op,
  input  logic            op_w,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] res
);

  localparam int unsigned CntW   = XLEN_LOG2 + 1;
  localparam bit          WordEn = (W_OPS != 0) && (XLEN == 64);

  function automatic logic [XLEN-1:0] sext32(input logic [XLEN-1:0] x);
    logic signed [31:0] lo;
    lo = x[31:0];
    return XLEN'(lo);
  endfunction

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d, cnt_last;
  logic [2:0]        op_q;
  logic              word_q, neg_q, rem_neg_q, div0_q;
  logic [XLEN-1:0]   dvd_q;
  logic [2*XLEN-1:0] mcand_q, prod_q, prod_nxt, prod_full, prod_fix;
  logic [XLEN-1:0]   mplier_q;
  logic [XLEN-1:0]   res_q, res_d;
  logic [XLEN-1:0]   mul_raw, mul_res, div_raw, div_res, div0_res;
  logic [XLEN-1:0]   quo_next, rem_next;
  logic              accept, mul_step, div_step, last;

  logic            word_in, is_div_in, sgn_a, sgn_b, a_neg, b_neg, div0_in;
  logic [XLEN-1:0] a_ext, b_ext, a_mag, b_mag;

  assign accept    = in_valid && (state_q == StIdle) && !flush;
  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign res       = res_q;

  // Decode the incoming request into operand magnitudes and result sign flags.
  always_comb begin
    word_in   = WordEn && op_w;
    is_div_in = op[2];
    if (is_div_in) begin
      sgn_a = (op == OpDiv) || (op == OpRem);
      sgn_b = sgn_a;
    end else begin
      // Word multiplies only keep the low half, so signedness is irrelevant
      sgn_a = !word_in && ((op == OpMulh) || (op == OpMulhsu));
      sgn_b = !word_in && (op == OpMulh);
    end
    a_ext = a;
    b_ext = b;
    if (word_in) begin
      a_ext = sgn_a ? sext32(a) : XLEN'(a[31:0]);
      b_ext = sgn_b ? sext32(b) : XLEN'(b[31:0]);
    end
    a_neg   = sgn_a && a_ext[XLEN-1];
    b_neg   = sgn_b && b_ext[XLEN-1];
    a_mag   = a_neg ? -a_ext : a_ext;
    b_mag   = b_neg ? -b_ext : b_ext;
    div0_in = is_div_in && (b_ext == '0);
  end

  // Result formation for multiply and divide, including sign fixup and word sign-extension.
  always_comb begin
    prod_nxt = prod_q + (mplier_q[0] ? mcand_q : '0);
`ifdef MUL_DIV_FAST_MUL_EN
    prod_full = (2 * XLEN)'(mcand_q[XLEN-1:0]) * (2 * XLEN)'(mplier_q);
`else
    prod_full = prod_nxt;
`endif
    prod_fix = neg_q ? -prod_full : prod_full;
    mul_raw  = ((op_q != OpMul) && !word_q) ? prod_fix[2*XLEN-1:XLEN] : prod_fix[XLEN-1:0];
    mul_res  = word_q ? sext32(mul_raw) : mul_raw;

    div_raw  = op_q[1] ? (rem_neg_q ? -rem_next : rem_next)
                       : (neg_q ? -quo_next : quo_next);
    div_res  = word_q ? sext32(div_raw) : div_raw;
    div0_res = op_q[1] ? dvd_q : '1;
    if (word_q) begin
      div0_res = sext32(div0_res);
    end

    cnt_last = word_q ? CntW'(31) : CntW'(XLEN - 1);
    last     = (cnt_q == cnt_last);
  end

  // Next-state logic: IDLE accepts, CALC iterates, DONE holds until the consumer takes it.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    res_d    = res_q;
    mul_step = 1'b0;
    div_step = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          state_d = StCalc;
          cnt_d   = '0;
        end
      end
      StCalc: begin
        if (div0_q) begin
          state_d = StDone;
          res_d   = div0_res;
        end else if (op_q[2]) begin
          div_step = 1'b1;
          cnt_d    = cnt_q + CntW'(1);
          if (last) begin
            state_d = StDone;
            res_d   = div_res;
          end
        end else begin
`ifdef MUL_DIV_FAST_MUL_EN
          state_d = StDone;
          res_d   = mul_res;
`else
          mul_step = 1'b1;
          cnt_d    = cnt_q + CntW'(1);
          if (last) begin
            state_d = StDone;
            res_d   = mul_res;
          end
`endif
        end
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    if (flush) begin
      state_d = StIdle;
    end
  end

  // State, request latch and shift-add multiplier registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      res_q     <= '0;
      op_q      <= '0;
      word_q    <= 1'b0;
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
      div0_q    <= 1'b0;
      dvd_q     <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      prod_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      if (accept) begin
        op_q      <= op;
        word_q    <= word_in;
        neg_q     <= a_neg ^ b_neg;
        rem_neg_q <= a_neg;
        div0_q    <= div0_in;
        dvd_q     <= a_ext;
        mcand_q   <= {{XLEN{1'b0}}, a_mag};
        mplier_q  <= b_mag;
        prod_q    <= '0;
      end else if (mul_step) begin
        prod_q   <= prod_nxt;
        mcand_q  <= mcand_q << 1;
        mplier_q <= mplier_q >> 1;
      end
    end
  end

  mul_div_divider #(
    .XLEN(XLEN)
  ) u_divider (
    .clk      (clk),
    .rst      (rst),
    .load     (accept && is_div_in),
    .step     (div_step),
    .word     (word_in),
    .dividend (a_mag),
    .divisor  (b_mag),
    .quo_next (quo_next),
    .rem_next (rem_next)
  );

endmodule

// File: doc/mul_div_unit.md
MUL_DIV_UNIT -- requirements
Module: mul_div_unit

Interface
REQ-001 SHALL have parameter XLEN, default 64, datapath width (32 or 64).
REQ-002 SHALL have parameter W_OPS, default 1, enables 32-bit word ops (legal only with XLEN=64).
REQ-003 SHALL have port clk, input, 1, sole clock, rising edge.
REQ-004 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have port in_valid, input, 1, request present.
REQ-006 SHALL have port in_ready, output, 1, unit can accept a request.
REQ-007 SHALL have port op, input, 3, RV M funct3: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU.
REQ-008 SHALL have port op_w, input, 1, word variant (MULW/DIVW/DIVUW/REMW/REMUW); ignored when W_OPS=0.
REQ-009 SHALL have ports a and b, input, XLEN each, operands rs1 and rs2.
REQ-010 SHALL have port flush, input, 1, pipeline kill; aborts any in-flight or held result.
REQ-011 SHALL have port out_valid, output, 1, result available.
REQ-012 SHALL have port out_ready, input, 1, consumer accepts result.
REQ-013 SHALL have port res, output, XLEN, result.

Function
REQ-014 SHALL implement FSM states IDLE, CALC, DONE; in_ready=1 only in IDLE.
REQ-015 SHALL accept a request on a rising edge with in_valid&in_ready&!flush, latch operands/op, go IDLE->CALC.
REQ-016 SHALL compute iteratively 1 bit/cycle: N=XLEN iterations, N=32 when op_w=1; CALC->DONE after N cycles; out_valid first high N+1 cycles after the accept edge.
REQ-017 SHALL hold res and out_valid stable in DONE until out_valid&out_ready, then return to IDLE (no same-cycle accept of a new request).
REQ-018 SHALL, for divide by zero, produce quotient all-ones and remainder = dividend, entering DONE 1 cycle after accept.
REQ-019 SHALL, for signed overflow (most-negative / -1), produce quotient = dividend and remainder 0 with full latency.
REQ-020 SHALL, for MULH/MULHSU/MULHU, return upper XLEN bits of the 2*XLEN product with operand signedness per RV spec; MUL returns lower XLEN bits.
REQ-021 SHALL, for op_w=1, operate on a[31:0]/b[31:0] and sign-extend bit 31 of the 32-bit result to XLEN; MULH* with op_w=1 SHALL behave as MULW.
REQ-022 SHALL perform signed divide by magnitude divide plus sign fixup: quotient negative iff signs differ; remainder takes dividend sign.
REQ-023 SHALL, on flush in any state, return to IDLE on the next edge with out_valid=0; a flush coincident with in_valid SHALL block the accept.
REQ-024 SHALL ignore in_valid, op, a, b outside IDLE.

Reset
REQ-025 SHALL on rst enter IDLE with out_valid=0, in_ready=1 after the edge, res=0, iteration counter 0.
REQ-026 SHALL give rst priority over flush and accept; rst mid-CALC discards the operation.

Configuration
REQ-027 SHALL, with MUL_DIV_FAST_MUL_EN defined, compute all multiply ops with one combinational product latched in one cycle (out_valid 2 cycles after accept); divides remain iterative.
REQ-028 SHALL, without MUL_DIV_FAST_MUL_EN, use the iterative shift-add multiplier of REQ-016 for multiplies.

Structure
REQ-029 SHALL place op encodings (funct3 values), FSM state encoding and the helper constant XLEN_LOG2 in shared package mul_div_pkg.
REQ-030 SHALL isolate the restoring divider datapath (partial remainder, quotient shift register) in sub-module mul_div_divider; multiply and control stay in mul_div_unit.

Verification
REQ-031 SHALL cover: XLEN=64, DIV a=-7, b=2 -> res=-3 (0xFFFF_FFFF_FFFF_FFFD), out_valid 65 cycles after accept; REM same operands -> res=-1.
REQ-032 SHALL cover: DIVU a=5, b=0 -> res=0xFFFF_FFFF_FFFF_FFFF 2 cycles after accept; REMU a=5, b=0 -> res=5.
REQ-033 SHALL cover: DIV a=0x8000_0000_0000_0000, b=-1 -> res=0x8000_0000_0000_0000; REM -> 0.
REQ-034 SHALL cover: MULHU a=b=0xFFFF_FFFF_FFFF_FFFF -> res=0xFFFF_FFFF_FFFF_FFFE; MULW a=0x0000_0000_7FFF_FFFF, b=2 -> res=0xFFFF_FFFF_FFFF_FFFE, 33 cycles (2 with MUL_DIV_FAST_MUL_EN).
REQ-035 SHALL cover: flush asserted at cycle 10 of a DIV -> in_ready=1 next cycle, out_valid never asserted; new MUL 3*4 then returns 12.
REQ-036 SHALL cover: result held with out_ready=0 for 5 cycles -> res/out_valid stable, in_ready=0; out_ready=1 -> IDLE next cycle.
